dac_par_tx: RTL and testbench

- Parallel-DAC transmitter. It is the output-side counterpart of the parallel ADC capture path.
- It accepts samples on a valid/ready stream into a small FIFO. It generates the DAC conversion clock by division of the system clock.
- It presents each sample on the DAC data bus so that the bus is stable across the DAC rising edge.
- It sits between the sample source (UART/NCO/loopback) and the 10-bit DAC pins.

---
 rtl/dac_par_tx.sv | 183 ++++++++++++++++++
 tb/tb_dac_par_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_par_tx.sv
// -----------------------------------------------------------------------------
// dac_par_tx - parallel-DAC transmitter
//
// Accepts samples on a valid/ready stream into a small FIFO, divides the
// system clock down to the DAC conversion clock and drives each sample onto
// the DAC data pins so that it is stable across the DAC rising edge.
// dac_db only changes on the edge where dac_clk goes low.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   dac_start    level: 1 = run conversion, 0 = stop
//   s_data       sample input (offset binary, or two's complement, see below)
//   s_valid      s_data valid
//   s_ready      FIFO can accept a sample
//   dac_db       DAC data pins (registered)
//   dac_clk      DAC conversion clock (registered)
//   dac_pd       DAC power-down, 1 = powered down
//   busy         block is not idle
//   underrun     sticky: FIFO was empty at a DAC period boundary
//   fifo_level   current FIFO occupancy
//
// Build option:
//   DAC_SIGNED_IN_EN  when defined, s_data is two's complement and its MSB is
//                     inverted on the way to dac_db (offset binary on the pins).
//                     Idle/reset value of dac_db is offset-binary midscale.
// -----------------------------------------------------------------------------
module dac_par_tx #(
  parameter int CLK_FRE    = 50,
  parameter int DAC_FRE    = 5000,
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dac_start,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_W-1:0]             dac_db,
  output logic                          dac_clk,
  output logic                          dac_pd,
  output logic                          busy,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV  = CLK_FRE * 1000 / DAC_FRE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  if (DIV < 2 || (DIV % 2) != 0) begin : g_div_chk
    $error("dac_par_tx: CLK_FRE*1000/DAC_FRE must be even and >= 2");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("dac_par_tx: FIFO_DEPTH must be a power of 2 and >= 4");
  end

  function automatic logic [DATA_W-1:0] to_offset_bin(input logic [DATA_W-1:0] v);
`ifdef DAC_SIGNED_IN_EN
    logic signed [DATA_W-1:0] sv;
    sv = signed'(v);
    return DATA_W'(sv) ^ MID;
`else
    return v;
`endif
  endfunction

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                push, pop;
  logic                fall_tick, stop_pend, set_unr, clr_unr;

  assign s_ready    = (level != LW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign fifo_level = level;
  assign dac_pd     = (state == IDLE);
  assign busy       = (state != IDLE);
  assign fall_tick  = (state == RUN) && (cnt == CW'(DIV - 1));

  // FIFO storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Empty-FIFO test uses the registered level, so a word pushed on a fall
  // tick into an empty FIFO still counts as underrun and is used next period.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    set_unr   = 1'b0;
    clr_unr   = 1'b0;
    case (state)
      IDLE: begin
        if (dac_start) begin
          state_nxt = PRIME;
          clr_unr   = 1'b1;
        end
      end
      PRIME: begin
        if (!dac_start) begin
          state_nxt = IDLE;
        end else if (level >= LW'(FIFO_DEPTH / 2)) begin
          state_nxt = RUN;
          pop       = 1'b1;
        end
      end
      RUN: begin
        if (fall_tick) begin
          if (stop_pend)         state_nxt = IDLE;
          else if (level == '0)  set_unr   = 1'b1;
          else                   pop       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter is zero on RUN entry, at every fall tick and outside RUN.
  always_comb begin
    cnt_nxt = '0;
    if (state == RUN && !fall_tick) cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dac_clk <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      dac_clk <= (state_nxt == RUN) && (cnt_nxt >= CW'(HALF));
    end
  end

  // A stop seen before a fall tick ends RUN at that tick; a stop first seen
  // on the tick itself lets that tick pop and ends RUN one period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 stop_pend <= 1'b0;
    else if (state_nxt != RUN)  stop_pend <= 1'b0;
    else if (fall_tick)         stop_pend <= !dac_start;
    else                        stop_pend <= stop_pend || !dac_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       underrun <= 1'b0;
    else if (clr_unr) underrun <= 1'b0;
    else if (set_unr) underrun <= 1'b1;
  end

  // dac_db: loaded only together with dac_clk going low; midscale outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 dac_db <= MID;
    else if (pop)               dac_db <= to_offset_bin(mem[rd_ptr]);
    else if (state_nxt != RUN)  dac_db <= MID;
  end

endmodule

// File: tb/tb_dac_par_tx.sv
module tb_dac_par_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dac_start = 1'b0;
  logic [9:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [9:0] dac_db;
  logic       dac_clk;
  logic       dac_pd;
  logic       busy;
  logic       underrun;
  logic [4:0] fifo_level;

  int checks = 0;
  int errors = 0;

  dac_par_tx #(.CLK_FRE(50), .DAC_FRE(5000), .DATA_W(10), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .dac_start(dac_start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .dac_db(dac_db), .dac_clk(dac_clk),
    .dac_pd(dac_pd), .busy(busy), .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] conv(input logic [9:0] v);
`ifdef DAC_SIGNED_IN_EN
    return {~v[9], v[8:0]};
`else
    return v;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    dac_start = 1'b0; s_valid = 1'b0; rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic push_words(input int base, input int inc, input int n);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1; s_data = 10'(base + k * inc);
      step(1);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    checks++;
    if ({dac_db, dac_clk, dac_pd, s_ready, busy, underrun, fifo_level} !== {10'd512, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      errors++; $display("FAIL reset_hold db=%0d clk=%b pd=%b rdy=%b busy=%b unr=%b lvl=%0d want 512 0 1 1 0 0 0", dac_db, dac_clk, dac_pd, s_ready, busy, underrun, fifo_level);
    end
    rst_n = 1'b1;
    step(4);
    checks++;
    if ({dac_db, dac_clk, dac_pd, s_ready, busy, underrun, fifo_level} !== {10'd512, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      errors++; $display("FAIL idle_after_reset db=%0d clk=%b pd=%b rdy=%b busy=%b unr=%b lvl=%0d want 512 0 1 1 0 0 0", dac_db, dac_clk, dac_pd, s_ready, busy, underrun, fifo_level);
    end
  endtask

  task automatic test_stream_underrun();
    int n;
    do_reset();
    push_words(0, 100, 8);
    checks++;
    if (fifo_level !== 5'd8 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_fill lvl=%0d busy=%b want 8 0", fifo_level, busy);
    end
    dac_start = 1'b1;
    step(1);
    checks++;
    if ({busy, dac_pd, dac_clk, dac_db} !== {1'b1, 1'b0, 1'b0, 10'd512}) begin
      errors++; $display("FAIL prime busy=%b pd=%b clk=%b db=%0d want 1 0 0 512", busy, dac_pd, dac_clk, dac_db);
    end
    step(1);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (dac_db !== conv(10'(k * 100)) || dac_clk !== (i >= 5) || underrun !== 1'b0) begin
          errors++; $display("FAIL stream k=%0d i=%0d db=%0d clk=%b unr=%b want db=%0d clk=%0d unr=0", k, i, dac_db, dac_clk, underrun, conv(10'(k * 100)), (i >= 5));
        end
        step(1);
      end
    end
    checks++;
    if ({underrun, dac_db, dac_clk, busy, dac_pd} !== {1'b1, conv(10'd700), 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL underrun unr=%b db=%0d clk=%b busy=%b pd=%b want 1 %0d 0 1 0", underrun, dac_db, dac_clk, busy, dac_pd, conv(10'd700));
    end
    step(5);
    checks++;
    if (dac_clk !== 1'b1 || busy !== 1'b1 || dac_db !== conv(10'd700)) begin
      errors++; $display("FAIL run_after_underrun clk=%b busy=%b db=%0d want 1 1 %0d", dac_clk, busy, dac_db, conv(10'd700));
    end
    dac_start = 1'b0;
    n = 0;
    while (busy && n < 20) begin step(1); n++; end
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL stop_latency cycles=%0d want 5", n);
    end
    checks++;
    if ({dac_db, dac_pd, dac_clk, underrun} !== {10'd512, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL idle_after_run db=%0d pd=%b clk=%b unr=%b want 512 1 0 1", dac_db, dac_pd, dac_clk, underrun);
    end
    dac_start = 1'b1;
    step(1);
    checks++;
    if (underrun !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL underrun_clear unr=%b busy=%b want 0 1", underrun, busy);
    end
    dac_start = 1'b0;
    step(1);
    checks++;
    if (busy !== 1'b0 || dac_pd !== 1'b1) begin
      errors++; $display("FAIL prime_abort busy=%b pd=%b want 0 1", busy, dac_pd);
    end
  endtask

  task automatic test_full_scoreboard();
    logic [9:0] exp_q[$];
    logic [9:0] want;
    logic       prev_clk;
    int extra, seen, lvl_viol, cyc, n;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      s_valid = 1'b1; s_data = 10'(k * 61 + 3);
      exp_q.push_back(s_data);
      step(1);
    end
    s_data = 10'd1000;
    checks++;
    if (fifo_level !== 5'd16 || s_ready !== 1'b0) begin
      errors++; $display("FAIL full lvl=%0d rdy=%b want 16 0", fifo_level, s_ready);
    end
    step(1);
    checks++;
    if (fifo_level !== 5'd16) begin
      errors++; $display("FAIL overflow_reject lvl=%0d want 16", fifo_level);
    end
    dac_start = 1'b1;
    extra = 0; seen = 0; lvl_viol = 0; cyc = 0;
    while (seen < 36 && cyc < 600) begin
      if (extra < 20) begin
        s_valid = 1'b1; s_data = 10'(500 + extra * 7);
        if (s_ready) begin exp_q.push_back(s_data); extra++; end
      end else begin
        s_valid = 1'b0;
      end
      prev_clk = dac_clk;
      step(1);
      cyc++;
      if (fifo_level > 5'd16) lvl_viol++;
      if (!prev_clk && dac_clk) begin
        want = (exp_q.size() > 0) ? conv(exp_q.pop_front()) : 10'h3ff;
        checks++;
        if (dac_db !== want) begin
          errors++; $display("FAIL scoreboard n=%0d db=%0d want %0d", seen, dac_db, want);
        end
        seen++;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (seen !== 36 || exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_count seen=%0d left=%0d want 36 0", seen, exp_q.size());
    end
    checks++;
    if (lvl_viol !== 0 || underrun !== 1'b0) begin
      errors++; $display("FAIL level_bound viol=%0d unr=%b want 0 0", lvl_viol, underrun);
    end
    dac_start = 1'b0;
    n = 0;
    while (busy && n < 30) begin step(1); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL full_stop busy=%b want 0", busy);
    end
  endtask

  task automatic test_stop_mid();
    do_reset();
    push_words(300, 1, 8);
    dac_start = 1'b1;
    step(2);
    checks++;
    if (dac_db !== conv(10'd300) || dac_clk !== 1'b0) begin
      errors++; $display("FAIL stop_entry db=%0d clk=%b want %0d 0", dac_db, dac_clk, conv(10'd300));
    end
    step(3);
    dac_start = 1'b0;
    step(1);
    checks++;
    if (dac_clk !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL stop_cnt4 clk=%b busy=%b want 0 1", dac_clk, busy);
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if (dac_clk !== 1'b1 || busy !== 1'b1 || dac_db !== conv(10'd300)) begin
        errors++; $display("FAIL stop_high i=%0d clk=%b busy=%b db=%0d want 1 1 %0d", i, dac_clk, busy, dac_db, conv(10'd300));
      end
    end
    step(1);
    checks++;
    if ({busy, dac_db, dac_pd, dac_clk, fifo_level, s_ready} !== {1'b0, 10'd512, 1'b1, 1'b0, 5'd7, 1'b1}) begin
      errors++; $display("FAIL stop_idle busy=%b db=%0d pd=%b clk=%b lvl=%0d rdy=%b want 0 512 1 0 7 1", busy, dac_db, dac_pd, dac_clk, fifo_level, s_ready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_words(20, 1, 8);
    dac_start = 1'b1;
    step(2);
    step(7);
    checks++;
    if (dac_clk !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset clk=%b busy=%b want 1 1", dac_clk, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dac_db, dac_clk, dac_pd, busy, underrun, fifo_level, s_ready} !== {10'd512, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL async_reset db=%0d clk=%b pd=%b busy=%b unr=%b lvl=%0d rdy=%b want 512 0 1 0 0 0 1", dac_db, dac_clk, dac_pd, busy, underrun, fifo_level, s_ready);
    end
    dac_start = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    checks++;
    if (busy !== 1'b0 || dac_db !== 10'd512) begin
      errors++; $display("FAIL post_reset busy=%b db=%0d want 0 512", busy, dac_db);
    end
  endtask

  task automatic test_sign_format();
    logic [9:0] w0, w1;
`ifdef DAC_SIGNED_IN_EN
    w0 = 10'd0;   w1 = 10'd512;
`else
    w0 = 10'd512; w1 = 10'd0;
`endif
    do_reset();
    push_words(512, -512, 2);
    push_words(0, 0, 6);
    dac_start = 1'b1;
    step(2);
    checks++;
    if (dac_db !== w0) begin
      errors++; $display("FAIL fmt_neg_full db=%0d want %0d", dac_db, w0);
    end
    step(10);
    checks++;
    if (dac_db !== w1) begin
      errors++; $display("FAIL fmt_zero db=%0d want %0d", dac_db, w1);
    end
    dac_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream_underrun();
    test_full_scoreboard();
    test_stop_mid();
    test_reset_mid();
    test_sign_format();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
